// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: wait-stated RAM with one memRDY pulse per CPU request.
// Optional machine control register at 16'hFFFE, enabled by defining LC3_MCR_EN.
module lc3_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memEN,
  input  logic        memWE,
  input  logic [15:0] memory_addr,
  input  logic [15:0] memory_din,
  output logic [15:0] memory_dout,
  output logic        memRDY,
  output logic [15:0] MCR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [15:0] dout_q, dout_d;
  logic        we_q, we_d;
  logic        commit;
  logic        in_ram;
  logic        is_mcr;
  logic [15:0] mcr_val;
  logic [15:0] rd_data;

  logic [15:0] ram [2**ADDR_W];

  assign in_ram = (addr_q[15:ADDR_W] == '0);

`ifdef LC3_MCR_EN
  logic [15:0] mcr_q, mcr_d;

  assign is_mcr  = (addr_q == 16'hFFFE);
  assign mcr_val = mcr_q;

  always_comb begin
    mcr_d = mcr_q;
    if (commit && we_q && is_mcr) mcr_d = din_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mcr_q <= 16'h8000;
    else      mcr_q <= mcr_d;
  end
`else
  assign is_mcr  = 1'b0;
  assign mcr_val = 16'h8000;
`endif

  assign MCR = mcr_val;

  // Unmapped addresses read as zero; decode uses only latched address.
  always_comb begin
    rd_data = '0;
    if (in_ram)      rd_data = ram[addr_q[ADDR_W-1:0]];
    else if (is_mcr) rd_data = mcr_val;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    dout_d  = dout_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memEN) begin
          addr_d  = memory_addr;
          din_d   = memory_din;
          we_d    = memWE;
          cnt_d   = 4'(WAIT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          commit  = 1'b1;
          if (!we_q) dout_d = rd_data;
        end
      end
      S_DONE:  state_d = memEN ? S_HOLD : S_IDLE;
      S_HOLD:  if (!memEN) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
    end
  end

  // RAM is not reset; commit is gated by the reset-cleared state, so a
  // reset during the wait phase suppresses the write.
  always_ff @(posedge clk) begin
    if (commit && we_q && in_ram) ram[addr_q[ADDR_W-1:0]] <= din_q;
  end

  assign memRDY      = (state_q == S_DONE);
  assign memory_dout = dout_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: driver queues expected responses,
// a monitor checks data and arrival cycle on every memRDY pulse.
module tb_lc3_mem_responder;

  localparam int WAIT_A = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        memEN, memWE;
  logic [15:0] memory_addr, memory_din, memory_dout, MCR;
  logic        memRDY;

  logic        b_en, b_we;
  logic [15:0] b_addr, b_din, b_dout, b_mcr;
  logic        b_rdy;

  always #5 clk = ~clk;

  lc3_mem_responder #(.ADDR_W(10), .WAIT(WAIT_A)) u_dut (
    .clk(clk), .rst(rst), .memEN(memEN), .memWE(memWE),
    .memory_addr(memory_addr), .memory_din(memory_din),
    .memory_dout(memory_dout), .memRDY(memRDY), .MCR(MCR)
  );

  lc3_mem_responder #(.ADDR_W(10), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .memEN(b_en), .memWE(b_we),
    .memory_addr(b_addr), .memory_din(b_din),
    .memory_dout(b_dout), .memRDY(b_rdy), .MCR(b_mcr)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [15:0] dout;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] model_dout = 16'h0000;

`ifdef LC3_MCR_EN
  localparam logic [15:0] MCR_AFTER_WR = 16'h0000;
`else
  localparam logic [15:0] MCR_AFTER_WR = 16'h8000;
`endif

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (memRDY === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_memRDY: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check16({mon_e.name, "_dout"}, memory_dout, mon_e.dout);
        vectors++;
        if (cyc != mon_e.cyc) begin
          miscompares++;
          $display("FAIL %s_cycle: got %0d expected %0d", mon_e.name, cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] din,
                       input logic [15:0] rd_exp, input string name);
    exp_t x;
    @(negedge clk);
    memEN = 1'b1; memWE = we; memory_addr = addr; memory_din = din;
    if (!we) model_dout = rd_exp;
    x.name = name; x.dout = model_dout; x.cyc = cyc + WAIT_A + 2;
    sbq.push_back(x);
  endtask

  task automatic finish_acc(input int hold, input string name);
    int n;
    n = 0;
    while (memRDY !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (memRDY !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: got no memRDY expected memRDY within 40 cycles", name);
    end
    repeat (hold) @(negedge clk);
    memEN = 1'b0;
  endtask

  // Inputs are scrambled right after acceptance: only latched values may matter.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] din,
                        input logic [15:0] rd_exp, input int hold, input string name);
    issue(we, addr, din, rd_exp, name);
    @(negedge clk);
    memory_addr = ~addr; memory_din = ~din; memWE = ~we;
    finish_acc(hold, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    memEN = 1'b0; memWE = 1'b0; memory_addr = '0; memory_din = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
    repeat (2) @(negedge clk);
    check16("rst_memRDY", {15'd0, memRDY}, 16'h0000);
    check16("rst_dout", memory_dout, 16'h0000);
    check16("rst_MCR", MCR, 16'h8000);
    check16("rst_b_rdy", {15'd0, b_rdy}, 16'h0000);
    rst = 1'b1;

    access(1'b1, 16'h0005, 16'hBEEF, 16'h0000, 0, "wr5");
    access(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 0, "rd5");
    access(1'b1, 16'h03FF, 16'h1234, 16'h0000, 0, "wr3ff");
    access(1'b0, 16'h03FF, 16'h0000, 16'h1234, 0, "rd3ff");
    access(1'b1, 16'h0000, 16'h7777, 16'h0000, 0, "wr0");
    access(1'b1, 16'h0400, 16'hAAAA, 16'h0000, 0, "wr400");
    access(1'b0, 16'h0400, 16'h0000, 16'h0000, 0, "rd400");
    access(1'b0, 16'h0000, 16'h0000, 16'h7777, 0, "rd0_noalias");

    access(1'b1, 16'h0020, 16'h0001, 16'h0000, 10, "hold_wr");
    access(1'b0, 16'h0020, 16'h0000, 16'h0001, 0, "hold_rd");

    access(1'b1, 16'hFFFE, 16'h0000, 16'h0000, 0, "mcr_wr");
    check16("mcr_after_wr", MCR, MCR_AFTER_WR);
    access(1'b0, 16'hFFFE, 16'h0000, 16'h0000, 0, "mcr_rd");
    access(1'b0, 16'h1234, 16'h0000, 16'h0000, 0, "rd_unmapped");

    access(1'b1, 16'h0010, 16'h1111, 16'h0000, 0, "wr10");
    access(1'b0, 16'h0010, 16'h0000, 16'h1111, 0, "rd10");
    @(negedge clk);
    memEN = 1'b1; memWE = 1'b1; memory_addr = 16'h0010; memory_din = 16'h5555;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check16("abort_memRDY", {15'd0, memRDY}, 16'h0000);
    check16("abort_MCR", MCR, 16'h8000);
    check16("abort_dout", memory_dout, 16'h0000);
    model_dout = 16'h0000;
    memWE = 1'b0;
    @(negedge clk);
    check16("abort_memRDY_held", {15'd0, memRDY}, 16'h0000);
    // Request already high at reset release: accepted on the first edge.
    begin
      exp_t x;
      model_dout = 16'h1111;
      x.name = "rd10_after_abort"; x.dout = model_dout; x.cyc = cyc + WAIT_A + 2;
      sbq.push_back(x);
    end
    rst = 1'b1;
    finish_acc(0, "rd10_after_abort");

    @(negedge clk);
    b_en = 1'b1; b_we = 1'b1; b_addr = 16'h0003; b_din = 16'h00C3;
    @(negedge clk);
    check16("w0_wr_rdy_A", {15'd0, b_rdy}, 16'h0000);
    @(negedge clk);
    check16("w0_wr_rdy_A1", {15'd0, b_rdy}, 16'h0001);
    b_en = 1'b0;
    @(negedge clk);
    check16("w0_wr_rdy_pulse", {15'd0, b_rdy}, 16'h0000);
    b_en = 1'b1; b_we = 1'b0; b_addr = 16'h0003;
    @(negedge clk);
    check16("w0_rd_rdy_A", {15'd0, b_rdy}, 16'h0000);
    @(negedge clk);
    check16("w0_rd_rdy_A1", {15'd0, b_rdy}, 16'h0001);
    check16("w0_rd_dout", b_dout, 16'h00C3);
    b_en = 1'b0;
    @(negedge clk);
    check16("w0_rd_rdy_pulse", {15'd0, b_rdy}, 16'h0000);

    repeat (5) @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
